// File: rtl/timer_arbiter_pkg.sv
// timer_arbiter_pkg
// Shared definitions for the timer arbiter: FSM state encoding and the
// default prescaler value (1 ms tick from a 12 MHz clock).
package timer_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        COUNT = ST_COUNT,
        DONE  = ST_DONE
    } state_t;

    localparam int CLK_HZ           = 12000000;
    localparam int DEFAULT_PRESCALE = CLK_HZ / 1000;

endpackage

// File: rtl/timer_arbiter_tick.sv
// tick_gen
// Prescaler producing one tick every PRESCALE clk cycles. pre_cnt counts
// 0..PRESCALE-1 and wraps; tick is high while pre_cnt sits at PRESCALE-1.
// tick is registered from the next count value so it tracks pre_cnt
// exactly while still being cleared by reset.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   clr   forces pre_cnt to 0 on the next edge (restarts the tick phase)
//   tick  prescaler tick
module tick_gen #(
    parameter int PRESCALE = 12000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] TERM = CW'(PRESCALE - 1);

    logic [CW-1:0] pre_cnt;
    logic [CW-1:0] pre_next;

    always_comb begin
        pre_next = '0;
        if (!clr && (pre_cnt != TERM)) begin
            pre_next = pre_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            pre_cnt <= pre_next;
            tick    <= (pre_next == TERM);
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter
// Shares one prescaled timebase and one down-counter between N_REQ
// requesters. Requests are granted round-robin; the granted duration is
// counted in ticks and the requester's done line pulses for one cycle.
// Optional feature (macro TIMER_ARBITER_ABORT_EN): if the granted
// requester drops req during LOAD or COUNT, the timer is abandoned with
// no done pulse and the round-robin pointer advances as after DONE.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   req      level request per requester
//   req_dur  packed durations, requester i at [i*DUR_W +: DUR_W]
//   gnt      one-hot grant, high from LOAD through DONE
//   done     one-cycle one-hot completion pulse
//   busy     high whenever the FSM is not IDLE
//   tick     prescaler tick (observation)
//
// state | meaning
// IDLE  | waiting for any req, round-robin pick from ptr
// LOAD  | sample granted duration, restart prescaler phase
// COUNT | decrement remaining on each tick
// DONE  | done pulse out, advance ptr, release grant
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DUR_W    = 8,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DUR_W-1:0] req_dur,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   tick
);

    localparam int IW = $clog2(N_REQ);

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gnt_idx;
    logic [DUR_W-1:0] remaining;

    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    ptr_next;
    logic [DUR_W-1:0] dur_sel;
    logic             abort_req;
    logic             clr;

    assign clr = (state == LOAD);

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .tick(tick)
    );

    // First set request at or after ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_found && req[(int'(ptr) + i) % N_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = IW'((int'(ptr) + i) % N_REQ);
            end
        end
    end

    assign ptr_next = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + IW'(1);
    assign dur_sel  = req_dur[int'(gnt_idx)*DUR_W +: DUR_W];

`ifdef TIMER_ARBITER_ABORT_EN
    assign abort_req = ~req[gnt_idx];
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            done      <= '0;
            busy      <= 1'b0;
            remaining <= '0;
            ptr       <= '0;
            gnt_idx   <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt           <= '0;
                        gnt[pick_idx] <= 1'b1;
                        gnt_idx       <= pick_idx;
                        busy          <= 1'b1;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort_req) begin
                        gnt       <= '0;
                        remaining <= '0;
                        ptr       <= ptr_next;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        remaining <= dur_sel;
                        if (dur_sel == '0) begin
                            done  <= gnt;
                            state <= DONE;
                        end else begin
                            state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (abort_req) begin
                        gnt       <= '0;
                        remaining <= '0;
                        ptr       <= ptr_next;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (tick) begin
                        remaining <= remaining - DUR_W'(1);
                        if (remaining == DUR_W'(1)) begin
                            done  <= gnt;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    gnt   <= '0;
                    ptr   <= ptr_next;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
